// File: rtl/spi_core.sv
// Button-driven SPI mode-0 master: button_0 increments the data register, button_1 sends it MSB first.
// Presses act 2 edges after first sampled high; a button_1 press during a frame is dropped, not queued.
module spi_core #(
    parameter int p_data_width = 8,
    parameter int p_sck_half   = 2
) (
    input  logic clk_100,
    input  logic s_rst_n,
    input  logic button_0,
    input  logic button_1,
    output logic sck,
    output logic cs_n,
    output logic mosi
);
    localparam int CW = (p_sck_half > 1) ? $clog2(p_sck_half) : 1;
    localparam int BW = (p_data_width > 1) ? $clog2(p_data_width) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(p_sck_half - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(p_data_width - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [p_data_width-1:0] DATA_ONE = p_data_width'(1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              b0_sync_q, b0_sync_d;
    logic [2:0]              b1_sync_q, b1_sync_d;
    logic                    b0_ev, b1_ev, half_done;
    logic [p_data_width-1:0] data_q, data_d;
    logic [p_data_width-1:0] shift_q, shift_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic                    sck_q, sck_d;
    logic                    cs_n_q, cs_n_d;
    logic                    mosi_q, mosi_d;

    always_comb begin
        // bit 0 is the first synchroniser stage, bit 2 the edge-detect stage
        b0_sync_d = {b0_sync_q[1:0], button_0};
        b1_sync_d = {b1_sync_q[1:0], button_1};
        b0_ev     = b0_sync_q[1] & ~b0_sync_q[2];
        b1_ev     = b1_sync_q[1] & ~b1_sync_q[2];
        half_done = (cnt_q == HALF_LAST);
        data_d    = b0_ev ? data_q + DATA_ONE : data_q;

        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;

        case (state_q)
            IDLE: begin
                sck_d  = 1'b0;
                cs_n_d = 1'b1;
                mosi_d = 1'b0;
                cnt_d  = '0;
                bit_d  = '0;
                if (b1_ev) begin
                    shift_d = data_q;
                    cs_n_d  = 1'b0;
                    mosi_d  = data_q[p_data_width-1];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (half_done) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SHIFT: begin
                if (!half_done) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = '0;
                    if (sck_q) begin
                        // zero fill means mosi falls to 0 after the last bit
                        sck_d   = 1'b0;
                        shift_d = shift_q << 1;
                        mosi_d  = shift_d[p_data_width-1];
                    end else if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        sck_d = 1'b1;
                        bit_d = bit_q + BIT_ONE;
                    end
                end
            end
            HOLD: begin
                if (half_done) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (!s_rst_n) begin
            state_q   <= IDLE;
            b0_sync_q <= '0;
            b1_sync_q <= '0;
            data_q    <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            b0_sync_q <= b0_sync_d;
            b1_sync_q <= b1_sync_d;
            data_q    <= data_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

    assign sck  = sck_q;
    assign cs_n = cs_n_q;
    assign mosi = mosi_q;
endmodule

// File: tb/tb_spi_core.sv
// Randomized button stimulus for spi_core; a press-count model predicts every frame,
// and a pin-level monitor decodes frames and checks SPI timing.
`timescale 1ns/1ps
module tb_spi_core;
    localparam int W   = 8;
    localparam int H   = 2;
    localparam int CLK = 10;

    logic clk_100  = 1'b0;
    logic s_rst_n  = 1'b0;
    logic button_0 = 1'b0;
    logic button_1 = 1'b0;
    logic sck, cs_n, mosi;

    int  n_chk = 0;
    int  n_err = 0;
    int  model_reg = 0;
    int  exp_q[$];
    int  frames_seen = 0;
    int  frames_exp  = 0;
    time t_b1 = 0;
    bit  mon_in_frame = 1'b0;

    logic p_sck = 1'b0, p_cs = 1'b1, p_mosi = 1'b0, rst_at_edge = 1'b0;
    int   nbits = 0, low_cnt = 0, val = 0;
    time  t_fall = 0;
    bit   first_rise = 1'b0;

    spi_core #(.p_data_width(W), .p_sck_half(H)) dut (
        .clk_100 (clk_100),
        .s_rst_n (s_rst_n),
        .button_0(button_0),
        .button_1(button_1),
        .sck     (sck),
        .cs_n    (cs_n),
        .mosi    (mosi)
    );

    always #(CLK/2) clk_100 = ~clk_100;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pin-level frame decoder: samples 1ns after every rising edge.
    initial begin
        forever begin
            @(posedge clk_100);
            rst_at_edge = s_rst_n;
            #1;
            if (!rst_at_edge) begin
                mon_in_frame = 1'b0;
            end else begin
                if (p_cs && !cs_n) begin
                    mon_in_frame = 1'b1;
                    nbits = 0; low_cnt = 0; val = 0; first_rise = 1'b1;
                    t_fall = $time - 1;
                    chk("b1_to_cs_fall_ns", int'(t_fall - t_b1), 2*CLK);
                end
                if (mon_in_frame && !cs_n) low_cnt++;
                if (mon_in_frame && (mosi !== p_mosi) && !(p_cs && !cs_n))
                    chk("mosi_moves_only_on_sck_fall", int'(p_sck && !sck), 1);
                if (mon_in_frame && !p_sck && sck) begin
                    chk("mosi_stable_at_sck_rise", int'(mosi), int'(p_mosi));
                    if (first_rise) begin
                        chk("cs_fall_to_first_sck_ns", int'($time - 1 - t_fall), H*CLK);
                        first_rise = 1'b0;
                    end
                    val = (val << 1) | int'(mosi);
                    nbits++;
                end
                if (mon_in_frame && !p_cs && cs_n) begin
                    mon_in_frame = 1'b0;
                    frames_seen++;
                    chk("sck_pulses", nbits, W);
                    chk("cs_low_cycles", low_cnt, (2*W+2)*H);
                    chk("idle_sck", int'(sck), 0);
                    chk("idle_mosi", int'(mosi), 0);
                    if (exp_q.size() == 0) chk("unexpected_frame", val, -1);
                    else                   chk("frame_value", val, exp_q.pop_front());
                end
            end
            p_sck = sck; p_cs = cs_n; p_mosi = mosi;
        end
    end

    // One press: hold = rising edges sampled high, gap = edges low afterwards.
    // starts = the model expects this button_1 press to open a frame.
    task automatic press(input bit b0, input bit b1, input int hold, input int gap, input bit starts);
        @(negedge clk_100);
        button_0 = b0;
        button_1 = b1;
        @(posedge clk_100);
        if (b1 && starts) begin
            exp_q.push_back(model_reg);
            frames_exp++;
            t_b1 = $time;
        end
        if (b0) model_reg = (model_reg + 1) % (1 << W);
        repeat (hold - 1) @(posedge clk_100);
        @(negedge clk_100);
        button_0 = 1'b0;
        button_1 = 1'b0;
        repeat (gap) @(posedge clk_100);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_100);
        s_rst_n = 1'b0;
        repeat (cycles) @(posedge clk_100);
        #1;
        chk("rst_sck", int'(sck), 0);
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_mosi", int'(mosi), 0);
        @(negedge clk_100);
        s_rst_n = 1'b1;
        model_reg = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk_100);
            #2;
            n++;
        end while ((mon_in_frame || !cs_n) && n < 300);
        if (n >= 300) chk("wait_idle_timeout", 0, 1);
        repeat (4) @(posedge clk_100);
    endtask

    task automatic wait_frame_start();
        int n = 0;
        while (cs_n && n < 50) begin
            @(posedge clk_100);
            #2;
            n++;
        end
        chk("frame_start_seen", int'(!cs_n), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hold, gap;

        do_reset(3);
        press(0, 1, 2, 2, 1); wait_idle();                        // 0x00

        repeat (20) press(1, 0, 2, 2, 0);
        press(0, 1, 2, 2, 1); wait_idle();                        // 0x14
        repeat (2) press(1, 0, 2, 2, 0);
        press(0, 1, 2, 2, 1); wait_idle();                        // 0x16
        press(1, 0, 2, 2, 0);
        press(0, 1, 2, 2, 1); wait_idle();                        // 0x17

        // busy: second button_1 dropped, mid-frame button_0 only shows next frame
        press(0, 1, 2, 2, 1);
        wait_frame_start();
        repeat (6) @(posedge clk_100);
        press(0, 1, 2, 2, 0);
        press(1, 0, 2, 2, 0);
        wait_idle();
        repeat (20) @(posedge clk_100);
        press(0, 1, 2, 2, 1); wait_idle();

        // simultaneous presses from IDLE with register 0x05
        do_reset(2);
        repeat (5) press(1, 0, 2, 2, 0);
        press(1, 1, 2, 2, 1); wait_idle();                        // 0x05
        press(0, 1, 2, 2, 1); wait_idle();                        // 0x06

        // wrap-around
        do_reset(2);
        repeat (256) press(1, 0, 1, 2, 0);
        press(0, 1, 2, 2, 1); wait_idle();                        // 0x00
        repeat (255) press(1, 0, 1, 2, 0);
        press(0, 1, 2, 2, 1); wait_idle();                        // 0xFF

        // randomized press runs, long holds must still give one event
        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(0, 6);
            for (int j = 0; j < n; j++)
                press(1, 0, $urandom_range(1, 4), $urandom_range(2, 5), 0);
            hold = $urandom_range(1, 4);
            gap  = $urandom_range(2, 5);
            if ($urandom_range(0, 2) == 0) press(1, 1, hold, gap, 1);
            else                           press(0, 1, hold, gap, 1);
            wait_idle();
        end

        // reset in the middle of SHIFT aborts the frame and clears the register
        repeat (3) press(1, 0, 2, 2, 0);
        press(0, 1, 2, 2, 1);
        wait_frame_start();
        repeat (10) @(posedge clk_100);
        void'(exp_q.pop_back());
        frames_exp--;
        @(negedge clk_100);
        s_rst_n = 1'b0;
        @(posedge clk_100);
        #1;
        chk("midrst_cs_n", int'(cs_n), 1);
        chk("midrst_sck", int'(sck), 0);
        chk("midrst_mosi", int'(mosi), 0);
        @(negedge clk_100);
        s_rst_n = 1'b1;
        model_reg = 0;
        repeat (3) @(posedge clk_100);
        press(0, 1, 2, 2, 1); wait_idle();                        // 0x00

        repeat (50) @(posedge clk_100);
        chk("frames_total", frames_seen, frames_exp);
        chk("expected_queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
